// File: rtl/id_operand_stage_pkg.sv
// Shared constants for the ID operand stage: datapath sizes, immediate
// format selectors and RV32I register-field positions.
package id_operand_stage_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = $clog2(NREG);

    localparam logic [2:0] SEXT_I     = 3'd0;
    localparam logic [2:0] SEXT_S     = 3'd1;
    localparam logic [2:0] SEXT_B     = 3'd2;
    localparam logic [2:0] SEXT_U     = 3'd3;
    localparam logic [2:0] SEXT_J     = 3'd4;
    localparam logic [2:0] SEXT_SHAMT = 3'd5;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

endpackage

// File: rtl/id_operand_stage_if.sv
// Bundle between upstream fetch/write-back (master) and the operand stage (slave).
interface id_operand_stage_if;
    import id_operand_stage_pkg::*;

    logic                 stall;
    logic                 flush;
    logic                 valid_in;
    logic [31:0]          inst;
    logic [XLEN-1:0]      pc;
    logic [2:0]           sext_op;
    logic                 wb_we;
    logic [REG_IDX_W-1:0] wb_wR;
    logic [XLEN-1:0]      wb_wD;
    logic                 valid_out;
    logic [XLEN-1:0]      pc_out;
    logic [REG_IDX_W-1:0] rR1_out;
    logic [REG_IDX_W-1:0] rR2_out;
    logic [REG_IDX_W-1:0] wR_out;
    logic [XLEN-1:0]      rD1;
    logic [XLEN-1:0]      rD2;
    logic [XLEN-1:0]      ext;

    modport master (
        output stall, flush, valid_in, inst, pc, sext_op, wb_we, wb_wR, wb_wD,
        input  valid_out, pc_out, rR1_out, rR2_out, wR_out, rD1, rD2, ext
    );

    modport slave (
        input  stall, flush, valid_in, inst, pc, sext_op, wb_we, wb_wR, wb_wD,
        output valid_out, pc_out, rR1_out, rR2_out, wR_out, rD1, rD2, ext
    );

endinterface

// File: rtl/id_operand_stage_regfile.sv
// NREG x XLEN register file: sync clear, hard-wired x0, two combinational
// read ports with write-first bypass from the write port.
module id_operand_stage_regfile
    import id_operand_stage_pkg::*;
#(
    parameter int XLEN = id_operand_stage_pkg::XLEN,
    parameter int NREG = id_operand_stage_pkg::NREG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] wR,
    input  logic [XLEN-1:0]         wD,
    input  logic [$clog2(NREG)-1:0] rR1,
    input  logic [$clog2(NREG)-1:0] rR2,
    output logic [XLEN-1:0]         rD1,
    output logic [XLEN-1:0]         rD2
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_en;

    assign wr_en = we && (wR != '0);

    // A write in the same cycle as rst is dropped by the reset branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wR] <= wD;
        end
    end

    always_comb begin
        rD1 = '0;
        rD2 = '0;
        if (rR1 != '0) rD1 = (wr_en && (wR == rR1)) ? wD : regs[rR1];
        if (rR2 != '0) rD2 = (wr_en && (wR == rR2)) ? wD : regs[rR2];
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage operand producer: register read with bypass, immediate
// extension, and a stall/flush pipeline register feeding EX.
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int XLEN = id_operand_stage_pkg::XLEN,
    parameter int NREG = id_operand_stage_pkg::NREG
) (
    input  logic               clk,
    input  logic               rst,
    id_operand_stage_if.slave  bus
);

    localparam int IDX_W = $clog2(NREG);

    function automatic logic [31:0] sext_imm(input logic [31:0] i, input logic [2:0] op);
        logic [31:0] r;
        case (op)
            SEXT_I:     r = {{20{i[31]}}, i[31:20]};
            SEXT_S:     r = {{20{i[31]}}, i[31:25], i[11:7]};
            SEXT_B:     r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            SEXT_U:     r = {i[31:12], 12'b0};
            SEXT_J:     r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            SEXT_SHAMT: r = {27'b0, i[24:20]};
            default:    r = '0;
        endcase
        return r;
    endfunction

    logic [IDX_W-1:0] rs1_p0, rs2_p0, rd_p0;
    logic [XLEN-1:0]  rd1_p0, rd2_p0, ext_p0;
    logic             wb_hit;

    assign rs1_p0 = bus.inst[RS1_LSB +: IDX_W];
    assign rs2_p0 = bus.inst[RS2_LSB +: IDX_W];
    assign rd_p0  = bus.inst[RD_LSB  +: IDX_W];
    assign ext_p0 = XLEN'(sext_imm(bus.inst, bus.sext_op));
    assign wb_hit = bus.wb_we && (bus.wb_wR != '0);

    id_operand_stage_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .we  (bus.wb_we),
        .wR  (bus.wb_wR),
        .wD  (bus.wb_wD),
        .rR1 (rs1_p0),
        .rR2 (rs2_p0),
        .rD1 (rd1_p0),
        .rD2 (rd2_p0)
    );

    // p0 -> p1: register into the EX-facing pipeline slot
    logic             vld_p1;
    logic [XLEN-1:0]  pc_p1, rd1_p1, rd2_p1, ext_p1;
    logic [IDX_W-1:0] rs1_p1, rs2_p1, rd_p1;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            vld_p1 <= 1'b0;
            pc_p1  <= '0;
            rd1_p1 <= '0;
            rd2_p1 <= '0;
            ext_p1 <= '0;
            rs1_p1 <= '0;
            rs2_p1 <= '0;
            rd_p1  <= '0;
        end else if (bus.stall) begin
            // Held operands track write-backs retiring while the slot is frozen.
            if (wb_hit && (bus.wb_wR == rs1_p1)) rd1_p1 <= bus.wb_wD;
            if (wb_hit && (bus.wb_wR == rs2_p1)) rd2_p1 <= bus.wb_wD;
        end else begin
            vld_p1 <= bus.valid_in;
            pc_p1  <= bus.pc;
            rd1_p1 <= rd1_p0;
            rd2_p1 <= rd2_p0;
            ext_p1 <= ext_p0;
            rs1_p1 <= rs1_p0;
            rs2_p1 <= rs2_p0;
            rd_p1  <= rd_p0;
        end
    end

    assign bus.valid_out = vld_p1;
    assign bus.pc_out    = pc_p1;
    assign bus.rD1       = rd1_p1;
    assign bus.rD2       = rd2_p1;
    assign bus.ext       = ext_p1;
    assign bus.rR1_out   = rs1_p1;
    assign bus.rR2_out   = rs2_p1;
    assign bus.wR_out    = rd_p1;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: reset, register file, bypass,
// immediate formats, stall refresh and flush priority.
module tb_id_operand_stage;
    import id_operand_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    id_operand_stage_if bus ();

    id_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
    endfunction

    task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
        bus.wb_we = we;
        bus.wb_wR = r;
        bus.wb_wD = d;
    endtask

    task automatic imm_chk(input string tag, input logic [31:0] i, input logic [2:0] op, input logic [31:0] exp);
        bus.inst    = i;
        bus.sext_op = op;
        tick();
        chk(tag, bus.ext, exp);
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;  bus.flush = 1'b0;  bus.valid_in = 1'b1;
        bus.inst  = mk(5, 6, 1);  bus.pc = 32'h100;  bus.sext_op = SEXT_I;
        wb(1'b0, 5'd0, 32'h0);
        tick();

        // x5 written, then reset (with a colliding write) must clear it
        rst = 1'b0;
        wb(1'b1, 5'd5, 32'hDEAD_0005);
        tick();
        rst = 1'b1;
        wb(1'b1, 5'd6, 32'hBEEF_0006);
        tick();
        chk("rst_valid", {31'b0, bus.valid_out}, 32'h0);
        chk("rst_pc", bus.pc_out, 32'h0);
        rst = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("rd_after_rst_rD1", bus.rD1, 32'h0);
        chk("rd_after_rst_rD2", bus.rD2, 32'h0);
        chk("rd_after_rst_valid", {31'b0, bus.valid_out}, 32'h1);
        chk("rd_after_rst_pc", bus.pc_out, 32'h100);
        chk("rd_after_rst_idx", {17'b0, bus.rR1_out, bus.rR2_out, bus.wR_out}, {17'b0, 5'd5, 5'd6, 5'd1});

        // plain write then read
        wb(1'b1, 5'd5, 32'h1234_5678);
        bus.inst = mk(0, 0, 0);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        bus.inst = mk(5, 0, 0);
        tick();
        chk("wr_rd_x5", bus.rD1, 32'h1234_5678);

        // x0 write ignored and x0 reads 0, including the bypass path
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        bus.inst = mk(0, 0, 0);
        tick();
        chk("x0_bypass_rD1", bus.rD1, 32'h0);
        chk("x0_bypass_rD2", bus.rD2, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("x0_read", bus.rD1, 32'h0);

        // same-cycle write-first bypass
        wb(1'b1, 5'd7, 32'hA5A5_0001);
        bus.inst = mk(5, 7, 0);
        tick();
        chk("bypass_rD2", bus.rD2, 32'hA5A5_0001);
        chk("bypass_rD1", bus.rD1, 32'h1234_5678);
        wb(1'b0, 5'd0, 32'h0);

        // immediate formats
        imm_chk("imm_I", 32'hFFF0_0093, SEXT_I, 32'hFFFF_FFFF);
        imm_chk("imm_S", 32'h0000_0223, SEXT_S, 32'h0000_0004);
        imm_chk("imm_B", 32'hFE00_0EE3, SEXT_B, 32'hFFFF_FFFC);
        imm_chk("imm_U", 32'h1234_50B7, SEXT_U, 32'h1234_5000);
        imm_chk("imm_J_pos", 32'h0080_006F, SEXT_J, 32'h0000_0008);
        imm_chk("imm_J_b11", 32'h0010_00EF, SEXT_J, 32'h0000_0800);
        imm_chk("imm_J_neg", 32'h8000_00EF, SEXT_J, 32'hFFF0_0000);
        imm_chk("imm_shamt", 32'h41F0_0013, SEXT_SHAMT, 32'h0000_001F);
        imm_chk("imm_op6", 32'hFFFF_FFFF, 3'd6, 32'h0);
        imm_chk("imm_op7", 32'hFFFF_FFFF, 3'd7, 32'h0);

        // valid_in=0 loads a bubble
        bus.valid_in = 1'b0;
        tick();
        chk("valid_in_low", {31'b0, bus.valid_out}, 32'h0);
        bus.valid_in = 1'b1;

        // stall with operand refresh
        wb(1'b1, 5'd3, 32'h1);
        bus.sext_op = SEXT_I;
        tick();
        wb(1'b0, 5'd0, 32'h0);
        bus.inst = mk(3, 5, 4);
        bus.pc   = 32'h200;
        tick();
        chk("stall_pre_rD1", bus.rD1, 32'h1);
        bus.stall = 1'b1;
        bus.inst  = mk(8, 9, 2);
        bus.pc    = 32'h300;
        wb(1'b1, 5'd3, 32'h9);
        tick();
        chk("stall_refresh_rD1", bus.rD1, 32'h9);
        chk("stall_hold_rD2", bus.rD2, 32'h1234_5678);
        chk("stall_hold_pc", bus.pc_out, 32'h200);
        chk("stall_hold_ext", bus.ext, 32'h5);
        chk("stall_hold_valid", {31'b0, bus.valid_out}, 32'h1);
        chk("stall_hold_rR1", {27'b0, bus.rR1_out}, 32'h3);
        wb(1'b1, 5'd5, 32'h0000_CAFE);
        tick();
        chk("stall_refresh_rD2", bus.rD2, 32'h0000_CAFE);
        chk("stall_keep_rD1", bus.rD1, 32'h9);
        bus.stall = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("release_pc", bus.pc_out, 32'h300);
        chk("release_rR1", {27'b0, bus.rR1_out}, 32'h8);

        // flush beats stall; the concurrent write-back still lands
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        bus.inst  = mk(3, 5, 4);
        wb(1'b1, 5'd10, 32'h55AA_55AA);
        tick();
        chk("flush_valid", {31'b0, bus.valid_out}, 32'h0);
        chk("flush_rD1", bus.rD1, 32'h0);
        chk("flush_rD2", bus.rD2, 32'h0);
        chk("flush_ext", bus.ext, 32'h0);
        chk("flush_pc", bus.pc_out, 32'h0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        bus.inst = mk(10, 3, 0);
        bus.pc   = 32'h400;
        tick();
        chk("post_flush_rD1", bus.rD1, 32'h55AA_55AA);
        chk("post_flush_rD2", bus.rD2, 32'h9);
        chk("post_flush_valid", {31'b0, bus.valid_out}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
